alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M extension. It runs an iterative shift-add multiply or a restoring divide over one shared 33-bit add/subtract step.
- The decoder launches it with start/op; the CPU holds its pipeline or PC while busy=1 and writes back result when done=1.
- It sits beside the single-cycle ALU and handles only the funct7=0000001 OP instructions.

---
 rtl/alu_muldiv_seq_pkg.sv | 50 +++++
 rtl/alu_muldiv_seq_if.sv | 25 ++
 rtl/alu_muldiv_seq_step.sv | 52 +++++
 rtl/alu_muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared types, encodings and op classification for the RV32M sequencer
package alu_muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNTW_DEF = 6;

  localparam logic [XLEN_DEF-1:0] XLEN_MIN_NEG = 32'h8000_0000;
  localparam logic [XLEN_DEF-1:0] ALL_ONES     = '1;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(input op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // MUL and every divide/remainder return the low word of the fixed-up value
  function automatic logic takes_low(input op_e op);
    return (op == MD_MUL) || op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - launch/result handshake between decoder and muldiv sequencer
interface alu_muldiv_seq_if
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/alu_muldiv_seq_step.sv
// rtl/alu_muldiv_seq_step.sv - one shift-add / restoring-divide iteration over a single 33-bit adder
module muldiv_step
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  mode_e           mode,
  input  logic [XLEN:0]   acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN:0]   next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0] lhs;
  logic [XLEN:0] rhs;
  logic [XLEN:0] sum;
  logic          cin;

  always_comb begin
    lhs     = acc_hi;
    rhs     = '0;
    cin     = 1'b0;
    next_hi = '0;
    next_lo = '0;

    // Divide subtracts via inverted operand plus carry-in so both modes share one adder
    if (mode == MODE_DIV) begin
      lhs = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
      rhs = ~{1'b0, operand};
      cin = 1'b1;
    end else if (acc_lo[0]) begin
      rhs = {1'b0, operand};
    end

    sum = lhs + rhs + {{XLEN{1'b0}}, cin};

    if (mode == MODE_DIV) begin
      if (!sum[XLEN]) begin
        next_hi = sum;
        next_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        next_hi = lhs;
        next_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      next_hi = {1'b0, sum[XLEN:1]};
      next_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer (IDLE/CALC/FIX/DONE)
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_muldiv_seq_if.slave    bus
);

  state_e          state, state_nx;
  op_e             op_r;
  logic            sign_a, sign_b;
  logic [XLEN:0]   acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] operand;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] result_r;

  op_e             op_in;
  logic            launch;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special;
  logic [XLEN-1:0] special_val;

  logic [XLEN:0]     step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [2*XLEN-1:0] fix_val, fixed;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = op_e'(bus.op);
  assign launch = (state == ST_IDLE) && bus.start && !bus.kill;
  assign a_neg  = a_signed(op_in) && bus.a[XLEN-1];
  assign b_neg  = b_signed(op_in) && bus.b[XLEN-1];
  assign abs_a  = a_neg ? -bus.a : bus.a;
  assign abs_b  = b_neg ? -bus.b : bus.b;
  assign bus.result = result_r;

  // Divide-by-zero and signed overflow bypass the iteration entirely
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (is_div(op_in) && (bus.b == '0)) begin
      special     = 1'b1;
      special_val = ((op_in == MD_DIV) || (op_in == MD_DIVU)) ? ALL_ONES : bus.a;
    end else if (((op_in == MD_DIV) || (op_in == MD_REM)) &&
                 (bus.a == XLEN_MIN_NEG) && (bus.b == ALL_ONES)) begin
      special     = 1'b1;
      special_val = (op_in == MD_DIV) ? XLEN_MIN_NEG : '0;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode    (is_div(op_r) ? MODE_DIV : MODE_MUL),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_comb begin
    fix_val = '0;
    fix_neg = 1'b0;
    if (!is_div(op_r)) begin
      fix_val = {acc_hi[XLEN-1:0], acc_lo};
      fix_neg = sign_a ^ sign_b;
    end else if ((op_r == MD_DIV) || (op_r == MD_DIVU)) begin
      fix_val = {{XLEN{1'b0}}, acc_lo};
      fix_neg = sign_a ^ sign_b;
    end else begin
      fix_val = {{XLEN{1'b0}}, acc_hi[XLEN-1:0]};
      fix_neg = sign_a;
    end
    fixed   = fix_neg ? -fix_val : fix_val;
    fix_res = takes_low(op_r) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bus.busy = (state != ST_IDLE);
    bus.done = (state == ST_DONE);
    case (state)
      ST_IDLE: if (launch) state_nx = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.kill)                        state_nx = ST_IDLE;
        else if (cnt == CNTW'(XLEN - 1))     state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = bus.kill ? ST_IDLE : ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= MD_MUL;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      cnt      <= '0;
      result_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            op_r    <= op_in;
            sign_a  <= a_neg;
            sign_b  <= b_neg;
            cnt     <= '0;
            acc_hi  <= '0;
            // Multiply shifts the multiplier out of lo; divide shifts the dividend out of Q
            acc_lo  <= is_div(op_in) ? abs_a : abs_b;
            operand <= is_div(op_in) ? abs_b : abs_a;
            if (special) result_r <= special_val;
          end
        end
        ST_CALC: begin
          if (!bus.kill) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNTW'(1);
          end
        end
        ST_FIX: begin
          if (!bus.kill) result_r <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  alu_muldiv_seq_if #(.XLEN(32)) bus ();

  alu_muldiv_seq #(.XLEN(32), .CNTW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] last_exp = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit sp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.special = sp;
    vecs.push_back(v);
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one start cycle; leaves caller one cycle later with operands scrambled
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done, input logic [31:0] exp, input bit sp,
                        output int unsigned k);
    sb_t e;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    if (expect_done) begin
      e.res = exp;
      e.cyc = k + (sp ? 1 : 34);
      sb.push_back(e);
      last_exp = exp;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.op = 3'($urandom_range(0, 7));
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    int errs;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'h0;
    bus.b = 32'h0;

    add(3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    add(3'b001, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    add(3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    add(3'b010, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0);
    add(3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0);
    add(3'b000, 32'h80000000,  32'h80000000, 32'h00000000, 1'b0);
    add(3'b011, 32'h80000000,  32'd2,        32'h00000001, 1'b0);
    add(3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0);
    add(3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0);
    add(3'b101, 32'd100,       32'd7,        32'd14,       1'b0);
    add(3'b111, 32'd100,       32'd7,        32'd2,        1'b0);
    add(3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    add(3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        1'b0);
    add(3'b100, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        1'b0);
    add(3'b110, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    add(3'b100, 32'h80000000,  32'd2,        32'hC0000000, 1'b0);
    add(3'b101, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 1'b0);
    add(3'b111, 32'hFFFFFFFF,  32'h10,       32'h0000000F, 1'b0);
    add(3'b101, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b0);
    add(3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1);
    add(3'b110, 32'd5,         32'd0,        32'd5,        1'b1);
    add(3'b100, 32'd9,         32'd0,        32'hFFFFFFFF, 1'b1);
    add(3'b111, 32'h1234ABCD,  32'd0,        32'h1234ABCD, 1'b1);
    add(3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);
    add(3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   {31'b0, bus.busy}, 32'd0);
    check("reset_done",   {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result,        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // MUL 7*-3 with a stray start while busy that must be ignored
    launch(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 1'b0, k);
    errs = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 5) begin
        bus.start = 1'b1;
        bus.op = 3'b101;
        bus.a = 32'd5;
        bus.b = 32'd0;
      end
      if (c == 6) bus.start = 1'b0;
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
    end
    check("busy_window", errs, 0);
    drain(10);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, vecs[i].special, k);
      drain(60);
    end

    // kill during CALC: no done, result held, immediate relaunch accepted
    launch(3'b000, 32'd123, 32'd456, 1'b0, 32'd0, 1'b0, k);
    wait_to(k + 10);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'd100;
    bus.b = 32'd7;
    begin
      sb_t e;
      e.res = 32'd14;
      e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    check("kill_busy",   {31'b0, bus.busy}, 32'd0);
    check("kill_result", bus.result,        last_exp);
    last_exp = 32'd14;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain(60);

    // start and kill together in IDLE launch nothing
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.kill = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'd5;
    bus.b = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    @(negedge clk);
    check("start_kill_busy",   {31'b0, bus.busy}, 32'd0);
    check("start_kill_result", bus.result,        last_exp);
    repeat (40) @(negedge clk);

    // synchronous reset in the middle of a divide
    launch(3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, 1'b0, k);
    wait_to(k + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_busy",   {31'b0, bus.busy}, 32'd0);
    check("midrst_done",   {31'b0, bus.done}, 32'd0);
    check("midrst_result", bus.result,        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    launch(3'b110, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 1'b0, k);
    drain(60);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
